// File: rtl/gfx_pkg.sv
// gfx -- shared types for the FP/integer issue block.
//   word          : 32-bit datapath word
//   fpint_opcode  : 4-bit operation code presented at the issue port
//   fpint_op      : one-hot-style per-field control word driven to gfx_fpint
//   FPINT_STAGES  : pipeline latency of gfx_fpint (operands in -> result out)
//   fpint_decode  : opcode -> control word; NOP and reserved codes give all-zero
package gfx;

    typedef logic [31:0] word;

    typedef enum logic [3:0] {
        FPINT_NOP  = 4'd0,
        FPINT_FADD = 4'd1,
        FPINT_FSUB = 4'd2,
        FPINT_FMUL = 4'd3,
        FPINT_IMUL = 4'd4,
        FPINT_FMIN = 4'd5,
        FPINT_FMAX = 4'd6,
        FPINT_ITOF = 4'd7,
        FPINT_FTOI = 4'd8
    } fpint_opcode;

    typedef struct packed {
        logic ftoi;
        logic itof;
        logic fmax;
        logic fmin;
        logic imul;
        logic fmul;
        logic fsub;
        logic fadd;
    } fpint_op;

    // Must be at least 2 (the tracking shift register is built from a slice).
    localparam int FPINT_STAGES = 3;

    function automatic fpint_op fpint_decode(input fpint_opcode op);
        fpint_op c;
        c = '0;
        case (op)
            FPINT_FADD: c.fadd = 1'b1;
            FPINT_FSUB: c.fsub = 1'b1;
            FPINT_FMUL: c.fmul = 1'b1;
            FPINT_IMUL: c.imul = 1'b1;
            FPINT_FMIN: c.fmin = 1'b1;
            FPINT_FMAX: c.fmax = 1'b1;
            FPINT_ITOF: c.itof = 1'b1;
            FPINT_FTOI: c.ftoi = 1'b1;
            default:    c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/gfx_fpint_issue_fifo.sv
// gfx_fpint_issue_fifo -- first-word-fall-through result queue.
//   clk, rst_n            : clock, synchronous active-low reset (empties queue)
//   push, push_q, push_tag: write one result and its tag
//   pop                   : consume the head entry
//   out_valid             : queue not empty
//   out_q, out_tag        : head entry (valid while out_valid)
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module gfx_fpint_issue_fifo
    import gfx::*;
#(
    parameter int DEPTH = 16,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  word              push_q,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output logic             out_valid,
    output word              out_q,
    output logic [TAG_W-1:0] out_tag
);

    localparam int PTR_W = $clog2(DEPTH);

    word              mem_q   [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];

    logic [PTR_W:0]   wr_ptr_reg;
    logic [PTR_W:0]   rd_ptr_reg;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                     (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign do_pop  = pop && !empty;
    // When full, a write is only legal if the head is leaving this same cycle
    // (the slot being written is the one being consumed).
    assign do_push = push && (!full || do_pop);

    // Head must be visible without a read cycle, so the storage is read
    // asynchronously (distributed RAM).
    assign out_valid = !empty;
    assign out_q     = mem_q[rd_ptr_reg[PTR_W-1:0]];
    assign out_tag   = mem_tag[rd_ptr_reg[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_reg[PTR_W-1:0]]   <= push_q;
            mem_tag[wr_ptr_reg[PTR_W-1:0]] <= push_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
        end
    end

endmodule

// File: rtl/gfx_fpint_issue.sv
// gfx_fpint_issue -- issue stage in front of the gfx_fpint pipeline.
//   clk, rst_n                      : clock, synchronous active-low reset
//   in_valid/in_ready               : instruction handshake
//   in_opcode, in_a, in_b, in_tag   : operation, operands, destination tag
//   fpint_a, fpint_b, fpint_ctl     : registered operands/control to gfx_fpint
//   fpint_q                         : gfx_fpint result, FPINT_STAGES after issue
//   out_valid/out_ready, out_q/tag  : result handshake (FWFT queue head)
// A credit counter covers the issue register, the FPINT_STAGES in-flight
// slots and the result queue, so a result always has a queue slot waiting.
module gfx_fpint_issue
    import gfx::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int TAG_W      = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  fpint_opcode      in_opcode,
    input  word              in_a,
    input  word              in_b,
    input  logic [TAG_W-1:0] in_tag,
    output word              fpint_a,
    output word              fpint_b,
    output fpint_op          fpint_ctl,
    input  word              fpint_q,
    output logic             out_valid,
    input  logic             out_ready,
    output word              out_q,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int S     = FPINT_STAGES;

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    word              a_reg;
    word              b_reg;
    fpint_op          ctl_reg;
    logic             iss_v_reg;
    logic [TAG_W-1:0] iss_tag_reg;
    logic [S-1:0]     v_sr_reg;
    logic [TAG_W-1:0] tag_sr_reg [S];

    logic accept;
    logic pop;

    // in_ready depends only on registered state.
    assign in_ready = (cnt_reg < CNT_W'(FIFO_DEPTH));
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    always_comb begin
        cnt_next = cnt_reg;
        case ({accept, pop})
            2'b10:   cnt_next = cnt_reg + CNT_W'(1);
            2'b01:   cnt_next = cnt_reg - CNT_W'(1);
            default: cnt_next = cnt_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            ctl_reg     <= '0;
            iss_v_reg   <= 1'b0;
            iss_tag_reg <= '0;
        end else begin
            cnt_reg   <= cnt_next;
            iss_v_reg <= accept;
            // Control drops back to NOP on idle cycles; operands hold.
            ctl_reg   <= accept ? fpint_decode(in_opcode) : '0;
            if (accept) begin
                a_reg       <= in_a;
                b_reg       <= in_b;
                iss_tag_reg <= in_tag;
            end
        end
    end

    // Valid/tag tracking aligned with the gfx_fpint pipeline: the last stage
    // lines up with the cycle its result appears on fpint_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_sr_reg <= '0;
        end else begin
            v_sr_reg <= {v_sr_reg[S-2:0], iss_v_reg};
        end
    end

    always_ff @(posedge clk) begin
        tag_sr_reg[0] <= iss_tag_reg;
        for (int i = 1; i < S; i++) begin
            tag_sr_reg[i] <= tag_sr_reg[i-1];
        end
    end

    assign fpint_a   = a_reg;
    assign fpint_b   = b_reg;
    assign fpint_ctl = ctl_reg;

    gfx_fpint_issue_fifo #(
        .DEPTH (FIFO_DEPTH),
        .TAG_W (TAG_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (v_sr_reg[S-1]),
        .push_q    (fpint_q),
        .push_tag  (tag_sr_reg[S-1]),
        .pop       (pop),
        .out_valid (out_valid),
        .out_q     (out_q),
        .out_tag   (out_tag)
    );

endmodule

// File: tb/tb_gfx_fpint_issue.sv
// Directed bench for gfx_fpint_issue with a small stand-in for gfx_fpint.
module tb_gfx_fpint_issue;
    import gfx::*;

    localparam int S     = FPINT_STAGES;
    localparam int DEPTH = 16;
    localparam int TW    = 6;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    fpint_opcode   in_opcode;
    word           in_a;
    word           in_b;
    logic [TW-1:0] in_tag;
    word           fpint_a;
    word           fpint_b;
    fpint_op       fpint_ctl;
    word           fpint_q;
    logic          out_valid;
    logic          out_ready;
    word           out_q;
    logic [TW-1:0] out_tag;

    gfx_fpint_issue #(.FIFO_DEPTH(DEPTH), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .fpint_a   (fpint_a),
        .fpint_b   (fpint_b),
        .fpint_ctl (fpint_ctl),
        .fpint_q   (fpint_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in execution unit: S register stages; only the 1.0 + 2.0 add is
    // evaluated as real arithmetic, everything else returns a ^ b.
    function automatic word unit_result(input word a, input word b, input fpint_op c);
        if (c.fadd && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a ^ b;
    endfunction

    word pipe [S];
    always @(posedge clk) begin
        pipe[0] <= unit_result(fpint_a, fpint_b, fpint_ctl);
        for (int i = 1; i < S; i++) pipe[i] <= pipe[i-1];
    end
    assign fpint_q = pipe[S-1];

    int compared_cnt = 0;
    int mismatch_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared_cnt++;
        assert (obs === exp) else begin
            mismatch_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Writing a full queue without a simultaneous pop must never happen.
    always @(posedge clk) begin
        if (rst_n && dut.u_fifo.push && !dut.u_fifo.do_pop)
            chk("push_into_full", 32'(dut.u_fifo.full), 32'd0);
    end

    // Scoreboard of accepted operations, in issue order.
    logic [TW-1:0] sb_tag [$];
    word           sb_q   [$];
    bit            sb_chk [$];
    int acc_cnt, pop_cnt, cyc, first_pop_cyc, last_pop_cyc;

    task automatic set_in(input logic v, input fpint_opcode op, input word a,
                          input word b, input logic [TW-1:0] t);
        in_valid  = v;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        in_tag    = t;
    endtask

    // Account for the handshakes that will complete at the coming edge,
    // then advance to the next falling edge.
    task automatic tick();
        if (rst_n) begin
            if (in_valid && in_ready) begin
                acc_cnt++;
                sb_tag.push_back(in_tag);
                sb_chk.push_back(in_opcode inside {FPINT_NOP, FPINT_FADD, FPINT_FSUB,
                    FPINT_FMUL, FPINT_IMUL, FPINT_FMIN, FPINT_FMAX, FPINT_ITOF, FPINT_FTOI});
                if (in_opcode == FPINT_FADD && in_a == 32'h3F80_0000 && in_b == 32'h4000_0000)
                    sb_q.push_back(32'h4040_0000);
                else
                    sb_q.push_back(in_a ^ in_b);
            end
            if (out_valid && out_ready) begin
                if (sb_tag.size() == 0) begin
                    chk("stale_result", 32'(out_valid), 32'd0);
                end else begin
                    logic [TW-1:0] t;
                    word q;
                    bit c;
                    t = sb_tag.pop_front();
                    q = sb_q.pop_front();
                    c = sb_chk.pop_front();
                    chk("out_tag", 32'(out_tag), 32'(t));
                    if (c) chk("out_q", out_q, q);
                    $display("pop  cyc=%0d tag=%0d q=%h", cyc, out_tag, out_q);
                end
                if (pop_cnt == 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                pop_cnt++;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && sb_tag.size() != 0; i++) tick();
        chk("drain_empty", 32'(sb_tag.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        fpint_op exp_fadd, exp_fmul, exp_itof;
        exp_fadd = '0; exp_fadd.fadd = 1'b1;
        exp_fmul = '0; exp_fmul.fmul = 1'b1;
        exp_itof = '0; exp_itof.itof = 1'b1;
        acc_cnt = 0; pop_cnt = 0; cyc = 0; first_pop_cyc = 0; last_pop_cyc = 0;

        rst_n = 1'b0;
        out_ready = 1'b1;
        set_in(1'b0, FPINT_NOP, 32'h0, 32'h0, '0);
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ctl", 32'(fpint_ctl), 32'd0);
        chk("rst_a", fpint_a, 32'd0);
        chk("rst_b", fpint_b, 32'd0);

        // Single FADD: result on the queue head exactly S+2 cycles after accept.
        set_in(1'b1, FPINT_FADD, 32'h3F80_0000, 32'h4000_0000, 6'd5);
        tick();
        set_in(1'b0, FPINT_NOP, 32'h0, 32'h0, '0);
        chk("fadd_ctl", 32'(fpint_ctl), 32'(exp_fadd));
        chk("fadd_a", fpint_a, 32'h3F80_0000);
        chk("fadd_b", fpint_b, 32'h4000_0000);
        for (int k = 1; k <= S + 3; k++) begin
            chk("fadd_latency", 32'(out_valid), 32'(k == S + 2));
            tick();
        end
        chk("fadd_popped", 32'(pop_cnt), 32'd1);

        // 40 back-to-back issues with the consumer always ready.
        pop_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            set_in(1'b1, FPINT_IMUL, 32'(i * 3 + 1), 32'hA5A5_0000 | 32'(i), TW'(i));
            chk("b2b_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        set_in(1'b0, FPINT_NOP, 32'h0, 32'h0, '0);
        drain(20);
        chk("b2b_pops", 32'(pop_cnt), 32'd40);
        chk("b2b_one_per_cycle", 32'(last_pop_cyc - first_pop_cyc), 32'd39);

        // Consumer stalled: exactly DEPTH accepts, then backpressure.
        out_ready = 1'b0;
        acc_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            set_in(1'b1, FPINT_FSUB, 32'h1000 + 32'(i), 32'h77, TW'(40 + i));
            tick();
        end
        set_in(1'b0, FPINT_NOP, 32'h0, 32'h0, '0);
        chk("stall_accepts", 32'(acc_cnt), 32'd16);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < S + 2; i++) tick();
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_still_blocked", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("ready_after_pop", 32'(in_ready), 32'd1);
        drain(40);

        // Full queue, then pop and issue together.
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_in(1'b1, FPINT_FMAX, 32'h2000 + 32'(i), 32'h5, TW'(i));
            tick();
        end
        set_in(1'b0, FPINT_NOP, 32'h0, 32'h0, '0);
        for (int i = 0; i < S + 2; i++) tick();
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        acc_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            set_in(1'b1, FPINT_FMIN, 32'h3000 + 32'(i), 32'h9, TW'(16 + i));
            if (i > 0) chk("full_flow_ready", 32'(in_ready), 32'd1);
            tick();
        end
        set_in(1'b0, FPINT_NOP, 32'h0, 32'h0, '0);
        chk("full_flow_accepts", 32'(acc_cnt), 32'd29);
        drain(60);

        // Reserved opcode between two ordinary ones.
        set_in(1'b1, FPINT_FMUL, 32'd11, 32'd22, 6'd8);
        tick();
        set_in(1'b1, fpint_opcode'(4'hF), 32'd33, 32'd44, 6'd9);
        chk("fmul_ctl", 32'(fpint_ctl), 32'(exp_fmul));
        tick();
        set_in(1'b1, FPINT_ITOF, 32'd55, 32'd66, 6'd10);
        chk("reserved_ctl", 32'(fpint_ctl), 32'd0);
        chk("reserved_a", fpint_a, 32'd33);
        tick();
        set_in(1'b0, FPINT_NOP, 32'h0, 32'h0, '0);
        chk("itof_ctl", 32'(fpint_ctl), 32'(exp_itof));
        tick();
        chk("idle_ctl", 32'(fpint_ctl), 32'd0);
        chk("idle_a_hold", fpint_a, 32'd55);
        drain(20);

        // Reset with work queued and in flight: everything is discarded.
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            set_in(1'b1, FPINT_FADD, 32'h4000 + 32'(i), 32'h1, TW'(20 + i));
            tick();
        end
        set_in(1'b0, FPINT_NOP, 32'h0, 32'h0, '0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb_tag.delete();
        sb_q.delete();
        sb_chk.delete();
        out_ready = 1'b1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_ctl", 32'(fpint_ctl), 32'd0);
        chk("mid_rst_a", fpint_a, 32'd0);
        for (int k = 0; k < S + 4; k++) begin
            chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
            tick();
        end
        pop_cnt = 0;
        set_in(1'b1, FPINT_FSUB, 32'h0F0F, 32'hF0F0, 6'd33);
        tick();
        set_in(1'b0, FPINT_NOP, 32'h0, 32'h0, '0);
        drain(20);
        for (int k = 0; k < 4; k++) tick();
        chk("post_rst_pops", 32'(pop_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatch_cnt);
        $finish;
    end

endmodule
